// File: rtl/gb_apu_pkg.sv
// Shared constants and types for the Game Boy APU envelope blocks.
package gb_apu_pkg;

    // Default widths of the volume and sweep-period fields
    localparam int VOL_W_DEF = 4;
    localparam int PER_W_DEF = 3;

    // Envelope channel FSM states
    typedef enum logic {
        ENV_IDLE = 1'b0,
        ENV_RUN  = 1'b1
    } env_state_t;

    // Latched envelope configuration: direction plus sweep period
    typedef struct packed {
        logic                 increasing;
        logic [PER_W_DEF-1:0] period;
    } env_cfg_t;

endpackage

// File: rtl/gb_envelope_channel.sv
// One envelope channel: IDLE/RUN FSM, tick counter, latched direction/period.
// Optional feature: define GB_ENV_ZOMBIE_EN to let live config writes
// disturb the current volume ("zombie mode").
module gb_envelope_channel
    import gb_apu_pkg::*;
#(
    parameter int VOL_W = VOL_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_vol_env,
    input  logic             start,
    input  logic             cfg_wr,
    input  logic [VOL_W-1:0] initial_volume,
    input  logic             envelope_increasing,
    input  logic [PER_W-1:0] num_envelope_sweeps,
    output logic [VOL_W-1:0] target_vol,
    output logic             env_active
);

    localparam logic [VOL_W-1:0] VMAX = '1;

    env_state_t       state_q, state_d;
    logic [PER_W-1:0] cnt_q,   cnt_d;
    logic [PER_W-1:0] per_q,   per_d;
    logic             inc_q,   inc_d;
    logic [VOL_W-1:0] vol_q,   vol_d;

`ifdef GB_ENV_ZOMBIE_EN
    // Volume disturbance applied by a live config write, modulo 2^VOL_W
    function automatic logic [VOL_W-1:0] zombie_adjust(
        input logic [VOL_W-1:0] v,
        input logic [PER_W-1:0] old_per,
        input logic             old_inc,
        input logic             new_inc
    );
        logic [VOL_W-1:0] r;
        r = v;
        if (old_per == '0 && old_inc) r = r + VOL_W'(1);
        if (!old_inc)                 r = r + VOL_W'(2);
        if (old_inc != new_inc)       r = '0 - r;
        return r;
    endfunction
`endif

    // Next-state: start wins; otherwise tick handling then config write
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        inc_d   = inc_q;
        vol_d   = vol_q;
        if (start) begin
            vol_d   = initial_volume;
            inc_d   = envelope_increasing;
            per_d   = num_envelope_sweeps;
            cnt_d   = num_envelope_sweeps;
            state_d = (num_envelope_sweeps != '0) ? ENV_RUN : ENV_IDLE;
        end else begin
            if (state_q == ENV_RUN && clk_vol_env) begin
                if (cnt_q > PER_W'(1)) begin
                    cnt_d = cnt_q - PER_W'(1);
                end else if (cnt_q == PER_W'(1)) begin
                    // Terminal tick: step with the old direction, reload with the newest period
                    cnt_d = cfg_wr ? num_envelope_sweeps : per_q;
                    if (inc_q) begin
                        if (vol_q != VMAX) vol_d = vol_q + VOL_W'(1);
                        if (vol_q == VMAX || vol_q == VMAX - VOL_W'(1)) state_d = ENV_IDLE;
                    end else begin
                        if (vol_q != '0) vol_d = vol_q - VOL_W'(1);
                        if (vol_q <= VOL_W'(1)) state_d = ENV_IDLE;
                    end
                end
            end
            if (cfg_wr) begin
                inc_d = envelope_increasing;
                per_d = num_envelope_sweeps;
                if (num_envelope_sweeps == '0) state_d = ENV_IDLE;
`ifdef GB_ENV_ZOMBIE_EN
                vol_d = zombie_adjust(vol_d, per_q, inc_q, envelope_increasing);
`endif
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ENV_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            inc_q   <= 1'b0;
            vol_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            inc_q   <= inc_d;
            vol_q   <= vol_d;
        end
    end

    assign target_vol = vol_q;
    assign env_active = (state_q == ENV_RUN);

endmodule

// File: rtl/gb_envelope_bank.sv
// Bank of NUM_CH independent volume-envelope channels sharing one tick strobe.
// Optional feature: define GB_ENV_ZOMBIE_EN (see gb_envelope_channel).
module gb_envelope_bank
    import gb_apu_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int VOL_W  = VOL_W_DEF,
    parameter int PER_W  = PER_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_vol_env,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       cfg_wr,
    input  logic [NUM_CH*VOL_W-1:0] initial_volume,
    input  logic [NUM_CH-1:0]       envelope_increasing,
    input  logic [NUM_CH*PER_W-1:0] num_envelope_sweeps,
    output logic [NUM_CH*VOL_W-1:0] target_vol,
    output logic [NUM_CH-1:0]       env_active
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gb_envelope_channel #(
            .VOL_W (VOL_W),
            .PER_W (PER_W)
        ) u_ch (
            .clk                 (clk),
            .reset               (reset),
            .clk_vol_env         (clk_vol_env),
            .start               (start[c]),
            .cfg_wr              (cfg_wr[c]),
            .initial_volume      (initial_volume[c*VOL_W +: VOL_W]),
            .envelope_increasing (envelope_increasing[c]),
            .num_envelope_sweeps (num_envelope_sweeps[c*PER_W +: PER_W]),
            .target_vol          (target_vol[c*VOL_W +: VOL_W]),
            .env_active          (env_active[c])
        );
    end

endmodule
